// File: rtl/output_framer_pkg.sv
// Shared types and constants for the output stream framer: frame-position state,
// per-beat tag struct and statistics width.
package output_framer_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [0:0] {
        S_WAIT_SOF = 1'b0,
        S_RUN      = 1'b1
    } framer_state_t;

    // Tags carried alongside each buffered beat; the top wraps them with the data
    // field into the full {eof,eol,sof,data} FIFO entry.
    typedef struct packed {
        logic eof;
        logic eol;
        logic sof;
    } beat_tag_t;

    // Counter width for a dimension of n positions, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Odd parity of a tag triple, available for integrity checking of buffered entries.
    function automatic logic tag_parity(input beat_tag_t t);
        return ^{t.eof, t.eol, t.sof};
    endfunction

endpackage

// File: rtl/framer_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with full/empty; registered write, no
// fall-through. A push on a full FIFO is accepted only when a pop frees a slot.
module framer_sync_fifo
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == FULL_CNT);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    // Empty reads as zero so the stream outputs are clean whenever nothing is valid.
    assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written, guarded by count_r.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/output_stream_framer.sv
// Tags result beats with sof/eol/eof from column/row counters and buffers them toward
// a ready/valid host stream. Optional frame/drop counters: OUTPUT_FRAMER_STATS_EN.
module output_stream_framer
    import output_framer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int DEPTH  = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic              o_overflow,
    output logic              o_sof_err,
    output logic [STAT_W-1:0] o_frame_cnt,
    output logic [STAT_W-1:0] o_drop_cnt
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef struct packed {
        beat_tag_t         tag;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    framer_state_t state_r;
    framer_state_t state_nx_s;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] pos_col_s;
    logic [ROW_W-1:0] pos_row_s;
    logic [COL_W-1:0] col_nx_s;
    logic [ROW_W-1:0] row_nx_s;
    logic             start_s;
    logic             wr_s;
    logic             eol_s;
    logic             eof_s;
    logic             sof_err_set_s;
    logic             pop_s;
    logic             drop_s;
    logic             full_s;
    logic             empty_s;
    logic             overflow_r;
    logic             sof_err_r;
    fifo_entry_t      push_entry_s;
    fifo_entry_t      head_entry_s;

    // Position of the incoming beat in the frame and the counter values that follow it.
    always_comb begin
        start_s       = i_valid && i_sof;
        wr_s          = i_valid && (i_sof || (state_r == S_RUN));
        sof_err_set_s = start_s && (state_r == S_RUN);
        pos_col_s     = start_s ? {COL_W{1'b0}} : col_r;
        pos_row_s     = start_s ? {ROW_W{1'b0}} : row_r;
        eol_s         = (pos_col_s == COL_LAST);
        eof_s         = eol_s && (pos_row_s == ROW_LAST);
        if (eof_s) begin
            col_nx_s   = {COL_W{1'b0}};
            row_nx_s   = {ROW_W{1'b0}};
            state_nx_s = S_WAIT_SOF;
        end else if (eol_s) begin
            col_nx_s   = {COL_W{1'b0}};
            row_nx_s   = pos_row_s + ROW_W'(1);
            state_nx_s = S_RUN;
        end else begin
            col_nx_s   = pos_col_s + COL_W'(1);
            row_nx_s   = pos_row_s;
            state_nx_s = S_RUN;
        end
        push_entry_s.tag.eof = eof_s;
        push_entry_s.tag.eol = eol_s;
        push_entry_s.tag.sof = start_s;
        push_entry_s.data    = i_data;
    end

    assign pop_s  = !empty_s && i_ready;
    // Counters advance on dropped beats too so frame geometry stays aligned.
    assign drop_s = wr_s && full_s && !pop_s;

    // Frame-position state machine and sticky error flags (a new event beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_WAIT_SOF;
            col_r      <= {COL_W{1'b0}};
            row_r      <= {ROW_W{1'b0}};
            overflow_r <= 1'b0;
            sof_err_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                state_r <= state_nx_s;
                col_r   <= col_nx_s;
                row_r   <= row_nx_s;
            end
            overflow_r <= drop_s || (overflow_r && !i_clr_err);
            sof_err_r  <= sof_err_set_s || (sof_err_r && !i_clr_err);
        end
    end

    framer_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign o_valid    = !empty_s;
    assign o_data     = head_entry_s.data;
    assign o_sof      = head_entry_s.tag.sof;
    assign o_eol      = head_entry_s.tag.eol;
    assign o_eof      = head_entry_s.tag.eof;
    assign o_overflow = overflow_r;
    assign o_sof_err  = sof_err_r;

`ifdef OUTPUT_FRAMER_STATS_EN
    logic [STAT_W-1:0] frame_cnt_r;
    logic [STAT_W-1:0] drop_cnt_r;

    // Frames counted on the eof write whether or not it fit; drops counted per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= {STAT_W{1'b0}};
            drop_cnt_r  <= {STAT_W{1'b0}};
        end else begin
            if (wr_s && eof_s) begin
                frame_cnt_r <= frame_cnt_r + STAT_W'(1);
            end
            if (drop_s) begin
                drop_cnt_r <= drop_cnt_r + STAT_W'(1);
            end
        end
    end

    assign o_frame_cnt = frame_cnt_r;
    assign o_drop_cnt  = drop_cnt_r;
`else
    assign o_frame_cnt = {STAT_W{1'b0}};
    assign o_drop_cnt  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_output_stream_framer.sv
// Self-checking bench for output_stream_framer: vector table, directed corner
// sequences and randomized traffic against a queue-based frame model.
module tb_output_stream_framer;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int DEPTH  = 8;
    localparam int EW     = DATA_W + 3;
`ifdef OUTPUT_FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              i_sof;
    logic              i_clr_err;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_sof;
    logic              o_eol;
    logic              o_eof;
    logic              o_overflow;
    logic              o_sof_err;
    logic [15:0]       o_frame_cnt;
    logic [15:0]       o_drop_cnt;

    output_stream_framer #(
        .DATA_W (DATA_W), .IMG_W (IMG_W), .IMG_H (IMG_H), .DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst), .i_data (i_data), .i_valid (i_valid), .i_sof (i_sof),
        .i_clr_err (i_clr_err), .o_data (o_data), .o_valid (o_valid), .i_ready (i_ready),
        .o_sof (o_sof), .o_eol (o_eol), .o_eof (o_eof), .o_overflow (o_overflow),
        .o_sof_err (o_sof_err), .o_frame_cnt (o_frame_cnt), .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of {eof,eol,sof,data}, frame index within the frame.
    logic [EW-1:0] mq[$];
    logic [EW-1:0] out_log[$];
    bit            m_in_frame;
    int            m_idx;
    bit            m_ovf;
    bit            m_err;
    logic [15:0]   m_frames;
    logic [15:0]   m_drops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        out_log.delete();
        m_in_frame = 1'b0;
        m_idx = 0;
        m_ovf = 1'b0;
        m_err = 1'b0;
        m_frames = 16'd0;
        m_drops = 16'd0;
    endtask

    task automatic model_step();
        bit pop;
        bit wr;
        bit s_sof;
        bit e_eol;
        bit e_eof;
        bit ovf_set;
        bit err_set;
        pop = (mq.size() > 0) && i_ready;
        wr = 1'b0;
        s_sof = 1'b0;
        ovf_set = 1'b0;
        err_set = 1'b0;
        if (i_valid) begin
            if (i_sof) begin
                if (m_in_frame) err_set = 1'b1;
                m_idx = 0;
                wr = 1'b1;
                s_sof = 1'b1;
            end else if (m_in_frame) begin
                wr = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (wr) begin
            e_eol = (m_idx % IMG_W) == IMG_W - 1;
            e_eof = m_idx == IMG_W * IMG_H - 1;
            if (e_eof) begin
                m_frames = m_frames + 16'd1;
                m_in_frame = 1'b0;
                m_idx = 0;
            end else begin
                m_in_frame = 1'b1;
                m_idx++;
            end
            if (mq.size() >= DEPTH) begin
                m_drops = m_drops + 16'd1;
                ovf_set = 1'b1;
            end else begin
                mq.push_back({e_eof, e_eol, s_sof, i_data});
            end
        end
        if (i_clr_err) begin
            m_ovf = 1'b0;
            m_err = 1'b0;
        end
        if (ovf_set) m_ovf = 1'b1;
        if (err_set) m_err = 1'b1;
    endtask

    task automatic compare_all();
        logic [EW-1:0] exp_head;
        exp_head = (mq.size() > 0) ? mq[0] : {EW{1'b0}};
        check("valid", 32'(o_valid), 32'(mq.size() > 0));
        check("head", 32'({o_eof, o_eol, o_sof, o_data}), 32'(exp_head));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("sof_err", 32'(o_sof_err), 32'(m_err));
        check("frame_cnt", 32'(o_frame_cnt), STATS ? 32'(m_frames) : 32'd0);
        check("drop_cnt", 32'(o_drop_cnt), STATS ? 32'(m_drops) : 32'd0);
    endtask

    task automatic tick();
        if (o_valid && i_ready) out_log.push_back({o_eof, o_eol, o_sof, o_data});
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_sof = 1'b0;
        i_clr_err = 1'b0;
        i_ready = 1'b0;
        i_data = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        compare_all();
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic s);
        i_valid = 1'b1;
        i_sof = s;
        i_data = d;
        tick();
        i_valid = 1'b0;
        i_sof = 1'b0;
    endtask

    task automatic drain(input int n);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic        v, s, r, c;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic        esof, eeol, eeof, eerr, eovf;
    } vec_t;

    vec_t vt[10];
    int   n_eof;

    initial begin
        rst = 1'b1;
        i_valid = 1'b0; i_sof = 1'b0; i_clr_err = 1'b0; i_ready = 1'b0; i_data = 16'd0;
        model_clear();
        do_reset();

        // Table: inputs applied at one edge, outputs expected right after it.
        vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0012, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0013, 1'b1, 16'h0013, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 1'b1, 16'h0021, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_valid = vt[i].v; i_sof = vt[i].s; i_ready = vt[i].r; i_clr_err = vt[i].c;
            i_data = vt[i].d;
            tick();
            check("tbl_valid", 32'(o_valid), 32'(vt[i].ev));
            check("tbl_data", 32'(o_data), 32'(vt[i].ed));
            check("tbl_tags", 32'({o_sof, o_eol, o_eof}), 32'({vt[i].esof, vt[i].eeol, vt[i].eeof}));
            check("tbl_flags", 32'({o_sof_err, o_overflow}), 32'({vt[i].eerr, vt[i].eovf}));
        end
        i_valid = 1'b0; i_sof = 1'b0; i_clr_err = 1'b0;

        // Contiguous frame 0..15 with ready held high.
        do_reset();
        i_ready = 1'b1;
        send(16'd0, 1'b1);
        check("t1_first_valid", 32'(o_valid), 32'd1);
        for (int i = 1; i < 16; i++) send(16'(i), 1'b0);
        drain(3);
        check("t1_count", 32'(out_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < out_log.size(); i++)
            check("t1_beat", 32'(out_log[i]),
                  32'({(i == 15), (i % 4 == 3), (i == 0), 16'(i)}));

        // Leading non-sof beats are discarded silently.
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 16; i++) send(16'(i), (i == 0));
        drain(3);
        check("t2_count", 32'(out_log.size()), 32'd16);
        check("t2_flags", 32'({o_sof_err, o_overflow}), 32'd0);

        // Stalled sink: eight buffered, eight dropped.
        do_reset();
        for (int i = 0; i < 16; i++) send(16'(i), (i == 0));
        check("t3_overflow", 32'(o_overflow), 32'd1);
        check("t3_drop_cnt", 32'(o_drop_cnt), STATS ? 32'd8 : 32'd0);
        check("t3_frame_cnt", 32'(o_frame_cnt), STATS ? 32'd1 : 32'd0);
        drain(10);
        check("t3_buffered", 32'(out_log.size()), 32'd8);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) send(16'(i), (i == 0));
        check("t4_full_no_ovf", 32'(o_overflow), 32'd0);
        i_ready = 1'b1;
        send(16'd8, 1'b0);
        check("t4_pushpop_ovf", 32'(o_overflow), 32'd0);
        drain(10);
        check("t4_total", 32'(out_log.size()), 32'd9);

        // Premature sof on beat 6 restarts the frame.
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(16'(i), (i == 0));
        for (int i = 0; i < 16; i++) send(16'(100 + i), (i == 0));
        drain(3);
        check("t5_sof_err", 32'(o_sof_err), 32'd1);
        check("t5_count", 32'(out_log.size()), 32'd22);
        n_eof = 0;
        foreach (out_log[i]) if (out_log[i][EW-1]) n_eof++;
        check("t5_eof_count", 32'(n_eof), 32'd1);
        if (out_log.size() == 22) begin
            check("t5_sof6", 32'(out_log[6][DATA_W]), 32'd1);
            check("t5_eof21", 32'(out_log[21][EW-1]), 32'd1);
        end

        // Sticky clear, and overflow coinciding with clear.
        do_reset();
        for (int i = 0; i < 9; i++) send(16'(i), (i == 0));
        send(16'd50, 1'b1);
        check("t6_set", 32'({o_sof_err, o_overflow}), 32'd3);
        i_clr_err = 1'b1;
        tick();
        check("t6_cleared", 32'({o_sof_err, o_overflow}), 32'd0);
        send(16'd51, 1'b0);
        i_clr_err = 1'b0;
        check("t6_set_wins", 32'({o_sof_err, o_overflow}), 32'd1);

        // Randomized traffic with a mid-run reset.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            i_valid = ($urandom_range(99) < 70);
            i_sof = ($urandom_range(11) == 0);
            i_ready = ($urandom_range(99) < 65);
            i_clr_err = ($urandom_range(49) == 0);
            i_data = 16'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
